// File: rtl/fwspi_memio_prefetch_if.sv
// Bus-side read port of the flash prefetch controller.
//   valid/addr : request from the CPU side (master)
//   ready/rdata: completion from the controller (slave); ready is combinational
interface fwspi_memio_prefetch_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;
  logic [31:0]           rdata;

  modport master (output valid, addr, input ready, rdata);
  modport slave  (input valid, addr, output ready, rdata);
endinterface

// File: rtl/fwspi_memio_prefetch.sv
// Memory-mapped SPI/QSPI flash read controller with a sequential prefetch FIFO.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   bus (slave)           : valid/addr request, combinational ready + rdata
//   cfg_quad, cfg_dummy   : data-phase mode and dummy clocks, latched per burst
//   cfg_flush             : pulse; drop FIFO and park the engine in IDLE
//   busy                  : chip select low or inter-command gap running
//   hit_count, miss_count : saturating statistics
//   flash_*               : SPI mode-0 pads (csb, clk, per-pin oeb/do, di)
module fwspi_memio_prefetch #(
  parameter int ADDR_WIDTH = 24,
  parameter int DEPTH      = 4,
  parameter int CSB_HIGH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  fwspi_memio_prefetch_if.slave bus,
  input  logic        cfg_quad,
  input  logic [3:0]  cfg_dummy,
  input  logic        cfg_flush,
  output logic        busy,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic [3:0]  flash_io_oeb,
  output logic [3:0]  flash_io_do,
  input  logic [3:0]  flash_io_di
);
  localparam int AW = ADDR_WIDTH;
  localparam int WA = AW - 2;
  localparam int PW = $clog2(DEPTH);
  localparam int GW = $clog2(CSB_HIGH + 1);
  localparam logic [7:0] CMD_SINGLE = (AW == 32) ? 8'h13 : 8'h03;
  localparam logic [7:0] CMD_QUAD   = (AW == 32) ? 8'h6C : 8'h6B;

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_CMD, S_ADDR, S_DUMMY, S_DATA} state_t;

  state_t          state, state_n;
  logic            phase, phase_n;        // 0: clk low / do update, 1: clk high
  logic [5:0]      bit_cnt, bit_cnt_n;    // bits left in the current state, minus one
  logic [GW-1:0]   gap_cnt, gap_n;
  logic [AW+7:0]   sh_out, sh_out_n;
  logic [31:0]     sh_in, sh_in_n;
  logic            push;
  logic [WA-1:0]   fetch_wa;
  logic            q_quad;
  logic [3:0]      q_dummy;
  logic [5:0]      word_last;

  logic [WA-1:0]   fa_mem [DEPTH];
  logic [31:0]     fd_mem [DEPTH];
  logic [PW:0]     wr_ptr, rd_ptr;
  logic            empty, full;
  logic            head_hit, waiting, restart, restarted;
  logic [WA-1:0]   req_wa;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^bus.addr[1:0];
  assign req_wa    = bus.addr[AW-1:2];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_hit  = !empty && (fa_mem[rd_ptr[PW-1:0]] == req_wa);
  // Requester is already waiting on the word the engine is fetching next.
  assign waiting   = empty && (state != S_IDLE) && (fetch_wa == req_wa);
  assign bus.ready = bus.valid && head_hit && !cfg_flush;
  assign bus.rdata = fd_mem[rd_ptr[PW-1:0]];
  assign restart   = bus.valid && !cfg_flush && !head_hit && !waiting;
  assign word_last = q_quad ? 6'd7 : 6'd31;

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    bit_cnt_n = bit_cnt;
    gap_n    = gap_cnt;
    sh_out_n = sh_out;
    sh_in_n  = sh_in;
    push     = 1'b0;
    case (state)
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_n   = S_CMD;
          phase_n   = 1'b0;
          bit_cnt_n = 6'd7;
          sh_out_n  = {(q_quad ? CMD_QUAD : CMD_SINGLE), fetch_wa, 2'b00};
        end else begin
          gap_n = gap_cnt - 1'b1;
        end
      end
      S_CMD, S_ADDR, S_DUMMY: begin
        phase_n = ~phase;
        if (phase) begin
          if (state != S_DUMMY) sh_out_n = sh_out << 1;
          if (bit_cnt == '0) begin
            if (state == S_CMD) begin
              state_n   = S_ADDR;
              bit_cnt_n = 6'(AW - 1);
            end else if (state == S_ADDR && q_quad && q_dummy != 4'd0) begin
              state_n   = S_DUMMY;
              bit_cnt_n = 6'(q_dummy) - 6'd1;
            end else begin
              state_n   = S_DATA;
              bit_cnt_n = word_last;
            end
          end else begin
            bit_cnt_n = bit_cnt - 6'd1;
          end
        end
      end
      S_DATA: begin
        // Hold the SPI clock low before the first bit of a word while full.
        if (phase || !(full && bit_cnt == word_last)) phase_n = ~phase;
        if (phase) begin
          sh_in_n = q_quad ? {sh_in[27:0], flash_io_di} : {sh_in[30:0], flash_io_di[1]};
          if (bit_cnt == '0) begin
            push      = 1'b1;
            bit_cnt_n = word_last;
          end else begin
            bit_cnt_n = bit_cnt - 6'd1;
          end
        end
      end
      default: ;
    endcase
    if (restart) begin
      state_n = S_GAP;
      phase_n = 1'b0;
      gap_n   = GW'(CSB_HIGH - 1);
    end else if (cfg_flush) begin
      state_n = S_IDLE;
      phase_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      phase   <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sh_out  <= '0;
      sh_in   <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_n;
      sh_out  <= sh_out_n;
      sh_in   <= sh_in_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_wa   <= '0;
      q_quad     <= 1'b0;
      q_dummy    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      restarted  <= 1'b0;
    end else begin
      if (restart) begin
        fetch_wa  <= req_wa;
        q_quad    <= cfg_quad;
        q_dummy   <= cfg_dummy;
        restarted <= 1'b1;
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end else if (push) begin
        fetch_wa <= fetch_wa + 1'b1;
      end
      if (restart || cfg_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (bus.ready) rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.ready) begin
        restarted <= 1'b0;
        if (!restarted && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end
    end
  end

  // Bytes arrive MSB-first in stream order; store first byte in [7:0].
  always_ff @(posedge clk) begin
    if (push) begin
      fa_mem[wr_ptr[PW-1:0]] <= fetch_wa;
      fd_mem[wr_ptr[PW-1:0]] <= {sh_in_n[7:0], sh_in_n[15:8], sh_in_n[23:16], sh_in_n[31:24]};
    end
  end

  logic active, io0_drv, io23_rel;
  assign active   = (state == S_CMD) || (state == S_ADDR) || (state == S_DUMMY) || (state == S_DATA);
  assign io0_drv  = (state == S_CMD) || (state == S_ADDR);
  // WP#/HOLD# are released once the quad bus turns around.
  assign io23_rel = q_quad && ((state == S_DUMMY) || (state == S_DATA));

  assign busy         = (state != S_IDLE);
  assign flash_csb    = !active;
  assign flash_clk    = active && phase;
  assign flash_io_oeb = {{2{!(active && !io23_rel)}}, 1'b1, !io0_drv};
  assign flash_io_do  = {{2{active && !io23_rel}}, 1'b0, io0_drv && sh_out[AW+7]};
endmodule

// File: tb/tb_fwspi_memio_prefetch.sv
module tb_fwspi_memio_prefetch;
  logic clk, reset;
  logic quad;
  logic [3:0] dummy;
  logic [1:0] v, flush, rdy, busy, csb, fclk;
  logic [1:0][31:0] a, rdt;
  logic [1:0][15:0] hitc, missc;
  logic [1:0][3:0] foeb, fdo, fdi;
  logic [1:0][7:0] cap_cmd;
  logic [1:0][31:0] cap_addr;
  logic [1:0][1:0] cap_o23c, cap_o23d;
  int cmp = 0;
  int err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] ad);
    logic [7:0] x;
    x = ad[7:0] ^ ad[15:8] ^ ad[23:16] ^ ad[31:24];
    return x * 8'd37 + 8'h5B;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] ad);
    return {mem_byte(ad + 32'd3), mem_byte(ad + 32'd2), mem_byte(ad + 32'd1), mem_byte(ad)};
  endfunction

  // Instance 0: 24-bit addressing; instance 1: 32-bit addressing.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int AW = (g == 0) ? 24 : 32;
    fwspi_memio_prefetch_if #(.ADDR_WIDTH(AW)) bus ();
    assign bus.valid = v[g];
    assign bus.addr  = a[g][AW-1:0];
    assign rdy[g]    = bus.ready;
    assign rdt[g]    = bus.rdata;

    fwspi_memio_prefetch #(.ADDR_WIDTH(AW), .DEPTH(4), .CSB_HIGH(2)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .cfg_quad(quad), .cfg_dummy(dummy), .cfg_flush(flush[g]),
      .busy(busy[g]), .hit_count(hitc[g]), .miss_count(missc[g]),
      .flash_csb(csb[g]), .flash_clk(fclk[g]), .flash_io_oeb(foeb[g]),
      .flash_io_do(fdo[g]), .flash_io_di(fdi[g])
    );

    // Behavioural flash: captures command/address on rising SPI clock,
    // shifts read data out on the falling edge.
    int nclk = 0;
    logic [7:0]  cmd_r = 8'h00;
    logic [31:0] fa_r = 32'h0;
    logic [31:0] fa_m;
    logic [3:0]  di_r = 4'h0;
    logic [1:0]  o23c = 2'b00, o23d = 2'b00;
    assign fa_m = (AW == 32) ? fa_r : (fa_r & 32'h00FF_FFFF);
    assign fdi[g] = di_r;
    assign cap_cmd[g] = cmd_r;
    assign cap_addr[g] = fa_m;
    assign cap_o23c[g] = o23c;
    assign cap_o23d[g] = o23d;

    always @(posedge fclk[g] or posedge csb[g]) begin
      if (csb[g]) nclk <= 0;
      else begin
        if (nclk == 0) o23c <= foeb[g][3:2];
        if (nclk == 8 + AW) o23d <= foeb[g][3:2];
        if (nclk < 8) cmd_r <= {cmd_r[6:0], fdo[g][0]};
        else if (nclk < 8 + AW) fa_r <= {fa_r[30:0], fdo[g][0]};
        nclk <= nclk + 1;
      end
    end

    always @(negedge fclk[g]) begin
      int k, d;
      logic q;
      logic [7:0] b;
      q = (cmd_r == 8'h6B) || (cmd_r == 8'h6C);
      d = q ? int'(dummy) : 0;
      k = nclk - (8 + AW + d);
      if (k >= 0) begin
        if (q) begin
          b = mem_byte(fa_m + 32'(k / 2));
          di_r <= (k % 2 == 0) ? b[7:4] : b[3:0];
        end else begin
          b = mem_byte(fa_m + 32'(k / 8));
          di_r <= {2'b00, b[7 - (k % 8)], 1'b0};
        end
      end
    end
  end

  // Present a request, hold it until ready (bounded), keep it through the
  // completing edge. ch = csb in cycles 1..3 after the request cycle.
  task automatic do_read(input int g, input logic [31:0] ad, output int lat,
                         output logic [31:0] rd, output logic [2:0] ch);
    @(negedge clk); v[g] = 1'b1; a[g] = ad; #1;
    lat = 0; ch = 3'b000;
    while (!rdy[g] && lat < 400) begin
      @(negedge clk); #1; lat++;
      if (lat <= 3) ch[3 - lat] = csb[g];
    end
    rd = rdt[g];
    if (!rdy[g]) lat = -1;
    @(posedge clk); #1; v[g] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    cmp++; if (csb !== 2'b11) begin err++; $display("FAIL rst_csb: got %b want 11", csb); end
    cmp++; if (fclk !== 2'b00) begin err++; $display("FAIL rst_fclk: got %b want 00", fclk); end
    cmp++; if (foeb[0] !== 4'b1111 || fdo[0] !== 4'h0) begin err++; $display("FAIL rst_io: oeb %b do %b want 1111 0000", foeb[0], fdo[0]); end
    cmp++; if (busy !== 2'b00 || rdy !== 2'b00) begin err++; $display("FAIL rst_busy_ready: busy %b ready %b want 00 00", busy, rdy); end
    cmp++; if (hitc[0] !== 16'd0 || missc[0] !== 16'd0) begin err++; $display("FAIL rst_counters: hit %0d miss %0d want 0 0", hitc[0], missc[0]); end
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    int lat; logic [31:0] rd; logic [2:0] ch;
    quad = 1'b0; dummy = 4'd0;
    do_read(0, 32'h100, lat, rd, ch);
    cmp++; if (lat !== 131) begin err++; $display("FAIL single_latency: got %0d want 131", lat); end
    cmp++; if (rd !== word_at(32'h100)) begin err++; $display("FAIL single_rdata: got %h want %h", rd, word_at(32'h100)); end
    cmp++; if (cap_cmd[0] !== 8'h03) begin err++; $display("FAIL single_cmd: got %h want 03", cap_cmd[0]); end
    cmp++; if (cap_addr[0] !== 32'h100) begin err++; $display("FAIL single_addr: got %h want 000100", cap_addr[0]); end
    cmp++; if (ch !== 3'b110) begin err++; $display("FAIL single_gap: got %b want 110", ch); end
    // Next sequential word is still in flight: wait, no restart.
    do_read(0, 32'h104, lat, rd, ch);
    cmp++; if (rd !== word_at(32'h104)) begin err++; $display("FAIL wait_rdata: got %h want %h", rd, word_at(32'h104)); end
    cmp++; if (missc[0] !== 16'd1 || hitc[0] !== 16'd1) begin err++; $display("FAIL wait_counts: miss %0d hit %0d want 1 1", missc[0], hitc[0]); end
  endtask

  task automatic test_quad_stream;
    int lat; logic [31:0] rd; logic [2:0] ch; logic [15:0] h0;
    quad = 1'b1; dummy = 4'd8;
    do_read(0, 32'h200, lat, rd, ch);
    cmp++; if (lat !== 99) begin err++; $display("FAIL quad_latency: got %0d want 99", lat); end
    cmp++; if (rd !== word_at(32'h200)) begin err++; $display("FAIL quad_rdata: got %h want %h", rd, word_at(32'h200)); end
    cmp++; if (cap_cmd[0] !== 8'h6B) begin err++; $display("FAIL quad_cmd: got %h want 6b", cap_cmd[0]); end
    cmp++; if (cap_o23c[0] !== 2'b00 || cap_o23d[0] !== 2'b11) begin err++; $display("FAIL quad_io23_oeb: cmd %b dummy %b want 00 11", cap_o23c[0], cap_o23d[0]); end
    h0 = hitc[0];
    repeat (70) @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      do_read(0, 32'h200 + 32'(4 * i), lat, rd, ch);
      cmp++; if (lat !== 0 || rd !== word_at(32'h200 + 32'(4 * i))) begin err++; $display("FAIL quad_hit%0d: lat %0d data %h want 0 %h", i, lat, rd, word_at(32'h200 + 32'(4 * i))); end
    end
    cmp++; if (hitc[0] !== h0 + 16'd3) begin err++; $display("FAIL quad_hit_count: got %0d want %0d", hitc[0], h0 + 16'd3); end
  endtask

  task automatic test_full_stall;
    int lat; logic [31:0] rd; logic [2:0] ch; logic stall_ok; int seen;
    repeat (200) @(negedge clk);
    stall_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (fclk[0] !== 1'b0 || csb[0] !== 1'b0 || busy[0] !== 1'b1) stall_ok = 1'b0;
    end
    cmp++; if (stall_ok !== 1'b1) begin err++; $display("FAIL stall_pins: got clk %b csb %b busy %b want 0 0 1", fclk[0], csb[0], busy[0]); end
    do_read(0, 32'h210, lat, rd, ch);
    cmp++; if (lat !== 0 || rd !== word_at(32'h210)) begin err++; $display("FAIL stall_pop: lat %0d data %h want 0 %h", lat, rd, word_at(32'h210)); end
    seen = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); #1;
      if (fclk[0] === 1'b1 && seen == 0) seen = i;
    end
    cmp++; if (seen == 0) begin err++; $display("FAIL stall_resume: flash_clk stayed %b want toggling", fclk[0]); end
  endtask

  task automatic test_jump;
    int lat; logic [31:0] rd; logic [2:0] ch; logic [15:0] m0;
    m0 = missc[0];
    do_read(0, 32'h1000, lat, rd, ch);
    cmp++; if (ch !== 3'b110) begin err++; $display("FAIL jump_gap: got %b want 110", ch); end
    cmp++; if (lat !== 99 || rd !== word_at(32'h1000)) begin err++; $display("FAIL jump_read: lat %0d data %h want 99 %h", lat, rd, word_at(32'h1000)); end
    cmp++; if (cap_cmd[0] !== 8'h6B || cap_addr[0] !== 32'h1000) begin err++; $display("FAIL jump_cmd: cmd %h addr %h want 6b 001000", cap_cmd[0], cap_addr[0]); end
    cmp++; if (missc[0] !== m0 + 16'd1) begin err++; $display("FAIL jump_miss: got %0d want %0d", missc[0], m0 + 16'd1); end
    // Previously buffered 0x214 was discarded, so it restarts.
    do_read(0, 32'h214, lat, rd, ch);
    cmp++; if (lat !== 99 || rd !== word_at(32'h214) || missc[0] !== m0 + 16'd2) begin err++; $display("FAIL jump_discard: lat %0d data %h miss %0d want 99 %h %0d", lat, rd, missc[0], word_at(32'h214), m0 + 16'd2); end
  endtask

  task automatic test_flush;
    int lat; logic [31:0] rd; logic [2:0] ch; logic [15:0] m0;
    quad = 1'b0; dummy = 4'd0;
    do_read(0, 32'h300, lat, rd, ch);
    cmp++; if (lat !== 131 || rd !== word_at(32'h300)) begin err++; $display("FAIL flush_pre: lat %0d data %h want 131 %h", lat, rd, word_at(32'h300)); end
    repeat (80) @(negedge clk);
    @(negedge clk); v[0] = 1'b1; a[0] = 32'h304; flush[0] = 1'b1; #1;
    cmp++; if (rdy[0] !== 1'b0) begin err++; $display("FAIL flush_vs_hit: ready %b want 0", rdy[0]); end
    @(posedge clk); #1; v[0] = 1'b0; flush[0] = 1'b0;
    @(negedge clk); #1;
    cmp++; if (csb[0] !== 1'b1 || busy[0] !== 1'b0 || fclk[0] !== 1'b0 || foeb[0] !== 4'b1111) begin err++; $display("FAIL flush_idle: csb %b busy %b clk %b oeb %b want 1 0 0 1111", csb[0], busy[0], fclk[0], foeb[0]); end
    m0 = missc[0];
    do_read(0, 32'h304, lat, rd, ch);
    cmp++; if (lat !== 131 || rd !== word_at(32'h304) || missc[0] !== m0 + 16'd1) begin err++; $display("FAIL flush_reread: lat %0d data %h miss %0d want 131 %h %0d", lat, rd, missc[0], word_at(32'h304), m0 + 16'd1); end
  endtask

  task automatic test_addr_wrap;
    int lat; logic [31:0] rd; logic [2:0] ch;
    quad = 1'b0; dummy = 4'd0;
    do_read(1, 32'hFFFF_FFFC, lat, rd, ch);
    cmp++; if (lat !== 147 || rd !== word_at(32'hFFFF_FFFC)) begin err++; $display("FAIL wrap_first: lat %0d data %h want 147 %h", lat, rd, word_at(32'hFFFF_FFFC)); end
    cmp++; if (cap_cmd[1] !== 8'h13 || cap_addr[1] !== 32'hFFFF_FFFC) begin err++; $display("FAIL wrap_cmd: cmd %h addr %h want 13 fffffffc", cap_cmd[1], cap_addr[1]); end
    do_read(1, 32'h0, lat, rd, ch);
    cmp++; if (lat < 0 || rd !== word_at(32'h0)) begin err++; $display("FAIL wrap_second: lat %0d data %h want %h", lat, rd, word_at(32'h0)); end
    cmp++; if (missc[1] !== 16'd1 || hitc[1] !== 16'd1) begin err++; $display("FAIL wrap_counts: miss %0d hit %0d want 1 1", missc[1], hitc[1]); end
  endtask

  task automatic test_reset_mid_cmd;
    @(negedge clk); v[0] = 1'b1; a[0] = 32'h400;
    @(posedge clk); #1; v[0] = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    cmp++; if (csb[0] !== 1'b0 || foeb[0][0] !== 1'b0) begin err++; $display("FAIL mid_cmd_pre: csb %b oeb0 %b want 0 0", csb[0], foeb[0][0]); end
    reset = 1'b1;
    @(negedge clk); #1;
    cmp++; if (csb[0] !== 1'b1 || busy[0] !== 1'b0 || foeb[0] !== 4'b1111 || fclk[0] !== 1'b0) begin err++; $display("FAIL mid_cmd_reset: csb %b busy %b oeb %b clk %b want 1 0 1111 0", csb[0], busy[0], foeb[0], fclk[0]); end
    cmp++; if (hitc !== '0 || missc !== '0) begin err++; $display("FAIL mid_cmd_counters: hit %h miss %h want 0 0", hitc, missc); end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; v = '0; a = '0; flush = '0; quad = 1'b0; dummy = 4'd0;
    test_reset;
    test_single_read;
    test_quad_stream;
    test_full_stall;
    test_jump;
    test_flush;
    test_addr_wrap;
    test_reset_mid_cmd;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
